// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst bridge: one 256-bit line read or write becomes a
// 4-beat 64-bit burst. Every output is a register or is decoded from registered state.
//
// state | meaning
// IDLE  | waiting for a cache read_i/write_i request
// RD    | read_o high, collecting burst_i beats into the line buffer
// WR    | write_o high, presenting line buffer beats on burst_o
// DONE  | resp_o pulse to the cache, returning to IDLE
module cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [LINE_W-1:0] line_i,
   output logic [LINE_W-1:0] line_o,
   output logic              resp_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   output logic [BURST_W-1:0] burst_o,
   input  logic [BURST_W-1:0] burst_i,
   input  logic              resp_i
);

   localparam int BEATS  = LINE_W / BURST_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int OFFS_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                          state;
   logic [BEAT_W-1:0]               beat;
   logic [BEATS-1:0][BURST_W-1:0]   line_buf;
   logic                            last_beat;
   logic [ADDR_W-1:0]               line_addr;

   assign last_beat = resp_i && (beat == BEAT_W'(BEATS - 1));
   assign line_addr = {address_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};

   // Write data is driven straight from the buffer so gaps in resp_i hold it steady.
   assign burst_o = (state == WR) ? line_buf[beat] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         beat      <= '0;
         line_buf  <= '0;
         line_o    <= '0;
         address_o <= '0;
         resp_o    <= 1'b0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
      end else begin
         resp_o <= 1'b0;
         case (state)
            IDLE: begin
               beat <= '0;
               if (write_i) begin
                  state     <= WR;
                  write_o   <= 1'b1;
                  line_buf  <= line_i;
                  address_o <= line_addr;
               end else if (read_i) begin
                  state     <= RD;
                  read_o    <= 1'b1;
                  address_o <= line_addr;
               end
            end
            RD: begin
               if (resp_i) begin
                  line_buf[beat] <= burst_i;
                  beat           <= beat + 1'b1;
                  if (last_beat) begin
                     state  <= DONE;
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     // The final beat is still on burst_i, so splice it in directly.
                     line_o <= {burst_i, line_buf[BEATS-2:0]};
                  end
               end
            end
            WR: begin
               if (resp_i) begin
                  beat <= beat + 1'b1;
                  if (last_beat) begin
                     state   <= DONE;
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               beat    <= '0;
               read_o  <= 1'b0;
               write_o <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               beat    <= '0;
               read_o  <= 1'b0;
               write_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
